// File: rtl/jtpopeye_obj_scan.sv
// jtpopeye_obj_scan: per-line object scanner.
// Reads the DMA object buffer once per line and collects the entries that
// intersect the requested line. Hits go into one bank of a double-buffered
// list while the drawer reads the other bank.
// Optional: define JTPOPEYE_OBJ_OVF_EN to get the list overflow flag (ovf_o);
// without it ovf_o is tied low and the drop tracking is left out.
//
// state | meaning
// IDLE  | waiting for line_start, obj_addr parked at 0
// SCAN  | issuing addresses, checking the entry read one cen earlier
// FLUSH | last address issued, checking the final entry
module jtpopeye_obj_scan #(
  parameter int ENTRIES = 256,
  parameter int MAXOBJ  = 16,
  parameter int OBJH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cen_i,
  input  logic                     line_start_i,
  input  logic [7:0]               v_i,
  output logic [7:0]               obj_addr_o,
  input  logic [28:0]              obj_data_i,
  input  logic [$clog2(MAXOBJ):0]  rd_idx_i,
  output logic [28:0]              rd_data_o,
  output logic [3:0]               rd_row_o,
  output logic [5:0]               rd_cnt_o,
  output logic                     busy_o,
  output logic                     ovf_o
);

  localparam int AW = $clog2(MAXOBJ);
  localparam int CW = AW + 1;
  localparam logic [7:0]    LAST   = 8'(ENTRIES - 1);
  localparam logic [CW-1:0] FULL   = CW'(MAXOBJ);
  localparam logic [8:0]    OBJH_L = 9'(OBJH);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    v_q, v_d;
  logic          chk_q, chk_d;
  logic          bank_q, bank_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [28:0]   rd_data_q;
  logic [3:0]    rd_row_q;

  // Two banks of MAXOBJ entries: {entry, row}; bank index is the MSB.
  logic [32:0]   mem_q [2*MAXOBJ];

  logic [7:0]    dy;
  logic          hit;
  logic          full;
  logic          store;
  logic [CW-1:0] wr_cnt_inc;

  // chk_q marks that obj_data_i holds an entry addressed by this scan.
  assign dy         = v_q - obj_data_i[15:8];
  assign hit        = chk_q && ({1'b0, dy} < OBJH_L);
  assign full       = (wr_cnt_q == FULL);
  assign store      = hit && !full;
  assign wr_cnt_inc = wr_cnt_q + {{AW{1'b0}}, store};

  // Next-state logic; a line_start overrides whatever the scan was doing.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    v_d      = v_q;
    chk_d    = 1'b0;
    bank_d   = bank_q;
    wr_cnt_d = wr_cnt_inc;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      IDLE: begin
        addr_d = 8'd0;
      end
      SCAN: begin
        chk_d = 1'b1;
        if (addr_q == LAST) begin
          state_d = FLUSH;
          addr_d  = 8'd0;
        end else begin
          addr_d = addr_q + 8'd1;
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Publishing includes a hit found on this same cen, so a line_start
    // landing on the FLUSH cen loses nothing.
    if (line_start_i) begin
      state_d  = SCAN;
      addr_d   = 8'd0;
      chk_d    = 1'b0;
      v_d      = v_i;
      bank_d   = ~bank_q;
      rd_cnt_d = wr_cnt_inc;
      wr_cnt_d = '0;
    end
  end

  // Scan state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= 8'd0;
      v_q      <= 8'd0;
      chk_q    <= 1'b0;
      bank_q   <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else if (cen_i) begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      v_q      <= v_d;
      chk_q    <= chk_d;
      bank_q   <= bank_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Hit write into the current write bank (bank before any toggle).
  always_ff @(posedge clk) begin
    if (cen_i && store) begin
      mem_q[{bank_q, wr_cnt_q[AW-1:0]}] <= {obj_data_i, dy[3:0]};
    end
  end

  // Drawer read port on the display bank; indices past the count read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_row_q  <= '0;
    end else if (cen_i) begin
      if (rd_idx_i < rd_cnt_q) begin
        {rd_data_q, rd_row_q} <= mem_q[{~bank_q, rd_idx_i[AW-1:0]}];
      end else begin
        rd_data_q <= '0;
        rd_row_q  <= '0;
      end
    end
  end

`ifdef JTPOPEYE_OBJ_OVF_EN
  logic drop;
  logic dropped_q;
  logic ovf_q;

  assign drop = hit && full;

  // Remember any dropped hit; expose it for the published scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dropped_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (cen_i) begin
      if (line_start_i) begin
        ovf_q     <= dropped_q | drop;
        dropped_q <= 1'b0;
      end else if (drop) begin
        dropped_q <= 1'b1;
      end
    end
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  assign obj_addr_o = addr_q;
  assign busy_o     = (state_q != IDLE);
  assign rd_cnt_o   = 6'(rd_cnt_q);
  assign rd_data_o  = rd_data_q;
  assign rd_row_o   = rd_row_q;

endmodule

// File: tb/tb_jtpopeye_obj_scan.sv
// Directed bench for jtpopeye_obj_scan with a registered buffer-RAM model.
module tb_jtpopeye_obj_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b1;
  logic        line_start = 1'b0;
  logic [7:0]  v = 8'd0;
  logic [7:0]  obj_addr;
  logic [28:0] obj_data = '0;
  logic [4:0]  rd_idx = 5'd0;
  logic [28:0] rd_data;
  logic [3:0]  rd_row;
  logic [5:0]  rd_cnt;
  logic        busy;
  logic        ovf;

  int n_chk = 0;
  int n_err = 0;

  logic [28:0] ram [256];

  typedef struct {
    logic [7:0] a0, y0, a1, y1, v;
    int         cnt;
    logic [7:0] ea0, ey0; logic [3:0] er0;
    logic [7:0] ea1, ey1; logic [3:0] er1;
  } vec_t;

  vec_t vecs [5];

`ifdef JTPOPEYE_OBJ_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  jtpopeye_obj_scan dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cen_i        (cen),
    .line_start_i (line_start),
    .v_i          (v),
    .obj_addr_o   (obj_addr),
    .obj_data_i   (obj_data),
    .rd_idx_i     (rd_idx),
    .rd_data_o    (rd_data),
    .rd_row_o     (rd_row),
    .rd_cnt_o     (rd_cnt),
    .busy_o       (busy),
    .ovf_o        (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cen) obj_data <= ram[obj_addr];

  function automatic logic [28:0] ent(input int a, input logic [7:0] y);
    logic [4:0] at;
    logic [7:0] cd;
    logic [7:0] x;
    at = 5'(a) ^ 5'h15;
    cd = 8'(a * 7 + 1);
    x  = 8'(a);
    return {at, cd, y, x};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] vv);
    v = vv;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic fill_bg(input logic [7:0] vv);
    for (int a = 0; a < 256; a++) ram[a] = ent(a, vv + 8'h80);
  endtask

  task automatic read_chk(input string nm, input int idx, input logic [28:0] ed, input logic [3:0] er);
    rd_idx = 5'(idx);
    tick();
    check({nm, "_data"}, 32'(rd_data), 32'(ed));
    check({nm, "_row"}, 32'(rd_row), 32'(er));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [28:0] mod10;
    logic [28:0] ed;
    int bad;

    vecs[0] = '{a0:8'd3, y0:8'h20, a1:8'd200, y1:8'h2F, v:8'h2F, cnt:2,
                ea0:8'd3, ey0:8'h20, er0:4'hF, ea1:8'd200, ey1:8'h2F, er1:4'h0};
    vecs[1] = '{a0:8'd5, y0:8'hF8, a1:8'd6, y1:8'h04, v:8'h03, cnt:1,
                ea0:8'd5, ey0:8'hF8, er0:4'hB, ea1:8'd0, ey1:8'h00, er1:4'h0};
    vecs[2] = '{a0:8'd0, y0:8'h40, a1:8'd255, y1:8'h41, v:8'h50, cnt:1,
                ea0:8'd255, ey0:8'h41, er0:4'hF, ea1:8'd0, ey1:8'h00, er1:4'h0};
    vecs[3] = '{a0:8'd0, y0:8'h80, a1:8'd1, y1:8'h7F, v:8'h80, cnt:2,
                ea0:8'd0, ey0:8'h80, er0:4'h0, ea1:8'd1, ey1:8'h7F, er1:4'h1};
    vecs[4] = '{a0:8'd10, y0:8'h11, a1:8'd20, y1:8'h21, v:8'h10, cnt:0,
                ea0:8'd0, ey0:8'h00, er0:4'h0, ea1:8'd0, ey1:8'h00, er1:4'h0};

    fill_bg(8'h00);
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(obj_addr), 32'd0);
    check("rst_cnt", 32'(rd_cnt), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    check("rst_row", 32'(rd_row), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    tick();

    // Overflow: 20 hits, list keeps the first 16.
    fill_bg(8'h10);
    for (int a = 0; a < 20; a++) ram[a] = ent(a, 8'h10);
    pulse(8'h10);
    repeat (257) tick();
    check("ovf_idle", 32'(busy), 32'd0);
    pulse(8'h55);
    check("ovf_cnt", 32'(rd_cnt), 32'd16);
    check("ovf_flag", 32'(ovf), 32'(EXP_OVF));
    for (int i = 0; i < 16; i++) read_chk("ovf_list", i, ent(i, 8'h10), 4'h0);
    read_chk("ovf_past", 16, 29'd0, 4'h0);

    // Asynchronous reset in the middle of a scan.
    check("mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_addr", 32'(obj_addr), 32'd0);
    check("mid_rst_cnt", 32'(rd_cnt), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("mid_rel_busy", 32'(busy), 32'd0);

    // Table of two-entry scans.
    for (int k = 0; k < 5; k++) begin
      fill_bg(vecs[k].v);
      ram[vecs[k].a0] = ent(int'(vecs[k].a0), vecs[k].y0);
      ram[vecs[k].a1] = ent(int'(vecs[k].a1), vecs[k].y1);
      pulse(vecs[k].v);
      repeat (256) tick();
      check("vec_busy_256", 32'(busy), 32'd1);
      tick();
      check("vec_busy_257", 32'(busy), 32'd0);
      check("vec_addr_idle", 32'(obj_addr), 32'd0);
      pulse(8'h00);
      check("vec_cnt", 32'(rd_cnt), 32'(vecs[k].cnt));
      check("vec_ovf", 32'(ovf), 32'd0);
      ed = (vecs[k].cnt > 0) ? ent(int'(vecs[k].ea0), vecs[k].ey0) : 29'd0;
      read_chk("vec_idx0", 0, ed, (vecs[k].cnt > 0) ? vecs[k].er0 : 4'h0);
      ed = (vecs[k].cnt > 1) ? ent(int'(vecs[k].ea1), vecs[k].ey1) : 29'd0;
      read_chk("vec_idx1", 1, ed, (vecs[k].cnt > 1) ? vecs[k].er1 : 4'h0);
      read_chk("vec_idx2", 2, 29'd0, 4'h0);
    end

    // Early line_start: partial list published, scan restarts at 0.
    fill_bg(8'h30);
    ram[10]  = ent(10, 8'h30);
    ram[150] = ent(150, 8'h30);
    pulse(8'h30);
    repeat (100) tick();
    check("abort_busy_pre", 32'(busy), 32'd1);
    pulse(8'h30);
    check("abort_busy", 32'(busy), 32'd1);
    check("abort_addr", 32'(obj_addr), 32'd0);
    check("abort_cnt", 32'(rd_cnt), 32'd1);

    // Display bank must not change while the new scan writes the same Y set.
    mod10 = ent(10, 8'h30) ^ 29'h1;
    ram[10] = mod10;
    rd_idx = 5'd0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rd_data !== ent(10, 8'h30) || rd_row !== 4'h0) bad++;
    end
    check("stable_reads", 32'(bad), 32'd0);
    read_chk("abort_idx1", 1, 29'd0, 4'h0);
    wait_idle();
    pulse(8'h00);
    check("restart_cnt", 32'(rd_cnt), 32'd2);
    read_chk("restart_idx0", 0, mod10, 4'h0);
    read_chk("restart_idx1", 1, ent(150, 8'h30), 4'h0);

    // Clock enable freezes the scan.
    pulse(8'h00);
    repeat (5) tick();
    check("cen_addr_run", 32'(obj_addr), 32'd5);
    cen = 1'b0;
    repeat (5) tick();
    check("cen_addr_hold", 32'(obj_addr), 32'd5);
    cen = 1'b1;
    tick();
    check("cen_addr_resume", 32'(obj_addr), 32'd6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
